// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard control unit
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MULDIV = 2'd1,
        LAST   = 2'd2
    } hazard_state_e;

    localparam int REGWRITE_EN_BIT = 1;

    typedef struct packed {
        logic [1:0] regwrite;
        logic       muxc;
        logic       muldiv;
    } ex_ctrl_t;

    // Control word of a bubble: writes nothing, loads nothing, not a mul/div.
    localparam ex_ctrl_t NOP_CTRL = '{regwrite: 2'b00, muxc: 1'b0, muldiv: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use / branch-ALU / branch-load hazard compare
import hazard_pkg::*;

module hazard_detect (
    input  logic [3:0] id_op1,
    input  logic [3:0] id_op2,
    input  logic       id_is_branch,
    input  logic [3:0] ex_op1,
    input  ex_ctrl_t   ex_ctrl,
    input  logic [3:0] mem_op1,
    input  logic       mem_muxc,
    output logic       hit
);

    logic ex_writes;
    logic load_use;
    logic branch_alu;
    logic branch_load;

    always_comb begin
        ex_writes   = (ex_ctrl != NOP_CTRL) && ex_ctrl.regwrite[REGWRITE_EN_BIT];
        // Register 0 is an ordinary register here: full 4-bit compares.
        load_use    = ex_ctrl.muxc && ex_writes && ((ex_op1 == id_op1) || (ex_op1 == id_op2));
        branch_alu  = id_is_branch && ex_writes && (ex_op1 == id_op1);
        branch_load = id_is_branch && mem_muxc && (mem_op1 == id_op1);
        hit         = load_use || branch_alu || branch_load;
    end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush generator; HAZARD_PERF_CNT_EN adds perf counters
import hazard_pkg::*;

module hazard_control_unit #(
    parameter int MULDIV_CYCLES = 4
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_op1,
    input  logic [3:0] id_op2,
    input  logic       id_is_branch,
    input  logic [3:0] ex_op1,
    input  logic [1:0] ex_regwrite,
    input  logic       ex_muxc,
    input  logic       ex_muldiv,
    input  logic [3:0] mem_op1,
    input  logic       mem_muxc,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_bubble,
    output logic       ex_hold,
    output logic       ifid_flush,
    output logic       busy
`ifdef HAZARD_PERF_CNT_EN
    , output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 2);

    hazard_state_e state;
    logic [3:0]    cnt;
    ex_ctrl_t      ex_ctrl;
    logic          data_hit;
    logic          muldiv_hold;
    logic          data_stall;

    assign ex_ctrl = '{regwrite: ex_regwrite, muxc: ex_muxc, muldiv: ex_muldiv};

    hazard_detect u_detect (
        .id_op1       (id_op1),
        .id_op2       (id_op2),
        .id_is_branch (id_is_branch),
        .ex_op1       (ex_op1),
        .ex_ctrl      (ex_ctrl),
        .mem_op1      (mem_op1),
        .mem_muxc     (mem_muxc),
        .hit          (data_hit)
    );

    // In LAST the mul/div is leaving EX, so ex_muldiv refers to it and is ignored.
    always_comb begin
        muldiv_hold = !rst && (((state == RUN) && ex_muldiv) || (state == MULDIV));
        data_stall  = !rst && !muldiv_hold && data_hit;
        pc_write    = !(muldiv_hold || data_stall);
        ifid_write  = !(muldiv_hold || data_stall);
        idex_bubble = data_stall;
        ex_hold     = muldiv_hold;
        ifid_flush  = !rst && branch_taken && pc_write;
        busy        = !rst && (state != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_muldiv) begin
                        cnt   <= CNT_INIT;
                        state <= (CNT_INIT == 4'd0) ? LAST : MULDIV;
                    end
                end
                MULDIV: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= LAST;
                    end
                end
                LAST:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (ifid_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    typedef struct packed {
        logic       rst;
        logic [3:0] id_op1;
        logic [3:0] id_op2;
        logic       id_is_branch;
        logic [3:0] ex_op1;
        logic [1:0] ex_regwrite;
        logic       ex_muxc;
        logic       ex_muldiv;
        logic [3:0] mem_op1;
        logic       mem_muxc;
        logic       branch_taken;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_op1, id_op2, ex_op1, mem_op1;
    logic       id_is_branch, ex_muxc, ex_muldiv, mem_muxc, branch_taken;
    logic [1:0] ex_regwrite;

    logic a_pc_write, a_ifid_write, a_idex_bubble, a_ex_hold, a_ifid_flush, a_busy;
    logic b_pc_write, b_ifid_write, b_idex_bubble, b_ex_hold, b_ifid_flush, b_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [1:0]  a_stall_cycles, a_flush_count;
    logic [15:0] b_stall_cycles, b_flush_count;
`endif

    // {pc_write, ifid_write, idex_bubble, ex_hold, ifid_flush, busy}
    logic [5:0] a_out, b_out;
    assign a_out = {a_pc_write, a_ifid_write, a_idex_bubble, a_ex_hold, a_ifid_flush, a_busy};
    assign b_out = {b_pc_write, b_ifid_write, b_idex_bubble, b_ex_hold, b_ifid_flush, b_busy};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .MULDIV_CYCLES(4)
`ifdef HAZARD_PERF_CNT_EN
        , .CNT_W(2)
`endif
    ) dut4 (
        .clk(clk), .rst(rst), .id_op1(id_op1), .id_op2(id_op2), .id_is_branch(id_is_branch),
        .ex_op1(ex_op1), .ex_regwrite(ex_regwrite), .ex_muxc(ex_muxc), .ex_muldiv(ex_muldiv),
        .mem_op1(mem_op1), .mem_muxc(mem_muxc), .branch_taken(branch_taken),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .idex_bubble(a_idex_bubble),
        .ex_hold(a_ex_hold), .ifid_flush(a_ifid_flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(a_stall_cycles), .flush_count(a_flush_count),
`endif
        .busy(a_busy)
    );

    hazard_control_unit #(
        .MULDIV_CYCLES(2)
    ) dut2 (
        .clk(clk), .rst(rst), .id_op1(id_op1), .id_op2(id_op2), .id_is_branch(id_is_branch),
        .ex_op1(ex_op1), .ex_regwrite(ex_regwrite), .ex_muxc(ex_muxc), .ex_muldiv(ex_muldiv),
        .mem_op1(mem_op1), .mem_muxc(mem_muxc), .branch_taken(branch_taken),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .idex_bubble(b_idex_bubble),
        .ex_hold(b_ex_hold), .ifid_flush(b_ifid_flush),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(b_stall_cycles), .flush_count(b_flush_count),
`endif
        .busy(b_busy)
    );

    task automatic apply(input vec_t v);
        rst          = v.rst;
        id_op1       = v.id_op1;
        id_op2       = v.id_op2;
        id_is_branch = v.id_is_branch;
        ex_op1       = v.ex_op1;
        ex_regwrite  = v.ex_regwrite;
        ex_muxc      = v.ex_muxc;
        ex_muldiv    = v.ex_muldiv;
        mem_op1      = v.mem_op1;
        mem_muxc     = v.mem_muxc;
        branch_taken = v.branch_taken;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(vec_t'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply(vec_t'{1'b1, 4'd0, 4'd5, 1'b1, 4'd5, 2'b10, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1});
        @(negedge clk);
        total++;
        if (a_out !== 6'b110000) begin
            bad++;
            $display("FAIL reset_dut4 got=%b want=%b", a_out, 6'b110000);
        end
        total++;
        if (b_out !== 6'b110000) begin
            bad++;
            $display("FAIL reset_dut2 got=%b want=%b", b_out, 6'b110000);
        end
        tick();
        apply(vec_t'(0));
        @(negedge clk);
        total++;
        if (a_out !== 6'b110000) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", a_out, 6'b110000);
        end
        tick();
    endtask

    task automatic test_load_use();
        vec_t       v[4] = '{
            vec_t'{1'b0, 4'd0, 4'd5, 1'b0, 4'd5, 2'b10, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0},
            vec_t'(0),
            vec_t'{1'b0, 4'd0, 4'd5, 1'b0, 4'd5, 2'b01, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0},
            vec_t'{1'b0, 4'd0, 4'd9, 1'b0, 4'd0, 2'b10, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}
        };
        logic [5:0] e[4] = '{6'b001000, 6'b110000, 6'b110000, 6'b001000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (a_out !== e[i]) begin
                bad++;
                $display("FAIL load_use[%0d] got=%b want=%b", i, a_out, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_branch_hazard();
        vec_t       v[6] = '{
            vec_t'{1'b0, 4'd3, 4'd0, 1'b1, 4'd3, 2'b10, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1},
            vec_t'{1'b0, 4'd3, 4'd0, 1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 4'd3, 1'b1, 1'b1},
            vec_t'{1'b0, 4'd3, 4'd0, 1'b1, 4'd0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1},
            vec_t'{1'b0, 4'd7, 4'd0, 1'b1, 4'd7, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0},
            vec_t'{1'b0, 4'd7, 4'd0, 1'b0, 4'd7, 2'b10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0},
            vec_t'{1'b0, 4'd3, 4'd0, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0}
        };
        logic [5:0] e[6] = '{6'b001000, 6'b001000, 6'b110010, 6'b001000, 6'b110000, 6'b110000};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(v[i]);
            @(negedge clk);
            total++;
            if (a_out !== e[i]) begin
                bad++;
                $display("FAIL branch_hazard[%0d] got=%b want=%b", i, a_out, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_muldiv4();
        logic       md[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       bt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [5:0] e[5]  = '{6'b000100, 6'b000101, 6'b000101, 6'b110001, 6'b110000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(vec_t'(0));
            ex_muldiv    = md[i];
            branch_taken = bt[i];
            @(negedge clk);
            total++;
            if (a_out !== e[i]) begin
                bad++;
                $display("FAIL muldiv4[%0d] got=%b want=%b", i, a_out, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        vec_t       lu   = vec_t'{1'b0, 4'd2, 4'd0, 1'b0, 4'd2, 2'b10, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        logic       md[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [5:0] e[9]  = '{6'b000100, 6'b000101, 6'b000101, 6'b110001, 6'b000100,
                              6'b000101, 6'b000101, 6'b001001, 6'b110000};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 7) apply(lu);
            else apply(vec_t'(0));
            ex_muldiv = md[i];
            @(negedge clk);
            total++;
            if (a_out !== e[i]) begin
                bad++;
                $display("FAIL back_to_back[%0d] got=%b want=%b", i, a_out, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_muldiv2();
        logic       md[3] = '{1'b1, 1'b1, 1'b0};
        logic [5:0] e[3]  = '{6'b000100, 6'b110001, 6'b110000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(vec_t'(0));
            ex_muldiv = md[i];
            @(negedge clk);
            total++;
            if (b_out !== e[i]) begin
                bad++;
                $display("FAIL muldiv2[%0d] got=%b want=%b", i, b_out, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic       rs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       md[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [5:0] e[9]  = '{6'b000100, 6'b000101, 6'b110000, 6'b110000, 6'b000100,
                              6'b000101, 6'b110000, 6'b000100, 6'b000101};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(vec_t'(0));
            rst       = rs[i];
            ex_muldiv = md[i];
            @(negedge clk);
            total++;
            if (a_out !== e[i]) begin
                bad++;
                $display("FAIL reset_mid[%0d] got=%b want=%b", i, a_out, e[i]);
            end
            tick();
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        @(negedge clk);
        total++;
        if ({a_stall_cycles, a_flush_count} !== 4'b0000) begin
            bad++;
            $display("FAIL perf_reset got=%b want=%b", {a_stall_cycles, a_flush_count}, 4'b0000);
        end
        for (int i = 0; i < 5; i++) begin
            apply(vec_t'{1'b0, 4'd0, 4'd5, 1'b0, 4'd5, 2'b10, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(vec_t'(0));
            branch_taken = 1'b1;
            tick();
        end
        apply(vec_t'(0));
        @(negedge clk);
        total++;
        if (a_stall_cycles !== 2'd3) begin
            bad++;
            $display("FAIL perf_stall_sat got=%0d want=%0d", a_stall_cycles, 3);
        end
        total++;
        if (a_flush_count !== 2'd2) begin
            bad++;
            $display("FAIL perf_flush got=%0d want=%0d", a_flush_count, 2);
        end
        do_reset();
        @(negedge clk);
        total++;
        if ({a_stall_cycles, a_flush_count} !== 4'b0000) begin
            bad++;
            $display("FAIL perf_clear got=%b want=%b", {a_stall_cycles, a_flush_count}, 4'b0000);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch_hazard();
        test_muldiv4();
        test_back_to_back();
        test_muldiv2();
        test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Stall/flush generator for the 5-stage pipeline; the counterpart to the forwarding path. Where forwarding cannot resolve a dependency, this block detects the hazard and freezes or bubbles the front end. It detects load-use and branch-operand hazards in ID, sequences multi-cycle multiply/divide occupancy of EX, and flushes IF/ID on taken branches. It sits beside the forwarding logic and drives the PC, IF/ID and ID/EX register enables.

## Interface
- MULDIV_CYCLES, 4, total EX occupancy of a mul/div instruction; legal range 2..15.
- CNT_W, 16, perf counter width (used only with macro).
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_op1, id_op2  in  4  source register ids of the instruction in ID.
- id_is_branch  in  1  ID instruction is a branch; it compares id_op1 in ID.
- ex_op1  in  4  destination id in EX.
- ex_regwrite  in  2  EX write code; bit 1 = writes register file.
- ex_muxc  in  1  EX instruction is a load.
- ex_muldiv  in  1  EX instruction is mul/div.
- mem_op1  in  4  destination id in MEM.
- mem_muxc  in  1  MEM instruction is a load.
- branch_taken  in  1  ID branch resolved taken this cycle.
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID enable.
- idex_bubble  out  1  load NOP into ID/EX.
- ex_hold  out  1  freeze ID/EX and EX/MEM input, insert NOP into MEM.
- ifid_flush  out  1  clear IF/ID.
- busy  out  1  FSM not in RUN.
- stall_cycles, flush_count  out  CNT_W  (macro only) perf counters.

## Operation
- FSM states are RUN, MULDIV and LAST, with cnt[3:0].
- RUN, ex_muldiv=1: assert ex_hold, pc_write=0 and ifid_write=0. Load cnt=MULDIV_CYCLES-2. If cnt loads 0, go to LAST; otherwise go to MULDIV.
- MULDIV: same stall outputs. Decrement cnt. When cnt==1, go to LAST.
- LAST: no hold. ex_muldiv is ignored because it is the same instruction leaving EX. Data-hazard rules apply. Next state is RUN.
- Data hazards are evaluated in RUN (without ex_muldiv) and in LAST:
  - Load-use: ex_muxc & ex_regwrite[1] & (ex_op1==id_op1 | ex_op1==id_op2).
  - Branch-ALU: id_is_branch & ex_regwrite[1] & ex_op1==id_op1.
  - Branch-load: id_is_branch & mem_muxc & mem_op1==id_op1.
  - Any hit sets pc_write=0, ifid_write=0, idex_bubble=1 for that cycle. These stalls are combinational and one cycle each; branch-on-load stalls 2 cycles total through the two rules.
- Priority is mul/div hold > data stall > flush.
- ifid_flush = branch_taken & pc_write. A taken branch is ignored in any stalled cycle.
- Register id 0 is not special; comparisons are full 4-bit.
- Reset:
  - While rst=1, outputs are forced to pc_write=1, ifid_write=1, idex_bubble=0, ex_hold=0, ifid_flush=0, busy=0.
  - The next state is RUN with cnt=0.
  - Reset mid-MULDIV abandons the sequence.

## Timing
- Hazard outputs are combinational from the current inputs and state, and are valid in the same cycle.
- Mul/div issued into EX at cycle T: ex_hold is high in cycles T..T+MULDIV_CYCLES-2 and low at T+MULDIV_CYCLES-1, when the instruction advances.
- busy is high from T+1 through the LAST cycle.
- A back-to-back mul/div is seen in RUN at T+MULDIV_CYCLES and starts a new sequence.
- Counters update on the clock edge and are 0 after reset.

## Configuration
- HAZARD_PERF_CNT_EN is the only compile option.
- Defined:
  - stall_cycles counts cycles with pc_write=0.
  - flush_count counts cycles with ifid_flush=1.
  - Both are saturating at all-ones and synchronously cleared by rst.
- Undefined: both ports and their registers are absent; behaviour is otherwise identical.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, MULDIV, LAST);
  - REGWRITE_EN_BIT=1;
  - the NOP control constants used for bubbles.
- One sub-module, hazard_detect, holds the purely combinational comparison of the three data-hazard rules. The FSM, counter and perf counters stay in the top module.

## Test plan
- ex_muxc=1, ex_regwrite=2'b10, ex_op1=5, id_op2=5 -> one cycle with pc_write=0 and idex_bubble=1. The next cycle with no hit has pc_write=1.
- id_is_branch=1, id_op1=3; load with op1=3 in EX, then in MEM -> 2 consecutive stall cycles; branch_taken during them gives ifid_flush=0.
- MULDIV_CYCLES=4, ex_muldiv held 4 cycles -> ex_hold=1,1,1,0 and busy=0,1,1,1, then RUN.
- MULDIV_CYCLES=2 -> ex_hold high exactly 1 cycle; FSM goes RUN->LAST->RUN.
- rst=1 pulsed in the 2nd MULDIV cycle -> outputs at their reset values immediately. The next cycle is RUN with ex_hold=0 unless ex_muldiv is still high, which restarts the sequence.
- HAZARD_PERF_CNT_EN with CNT_W=2, more than 3 stall cycles -> stall_cycles saturates at 3.
